seg_scan_driver: RTL

Four-digit multiplexed seven-segment display driver that sits directly downstream of the CPU datapath in the top-level and produces the board's `Dis`/`Cs` pins. It takes a 16-bit hex value with a load strobe and scans it out one digit at a time, least-significant digit first. Loads are double-buffered so that a value can never tear across a frame. Optional leading-zero blanking and a per-digit decimal point are provided.

---
 rtl/seg_scan_driver.sv | 105 ++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous double-buffered loads.
// Digits scan LSD first; segments and selects are active-low and registered.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] Value,
  input  logic        Load,
  input  logic [3:0]  Dp,
  input  logic        Blank_lz,
  output logic [7:0]  Dis,
  output logic [3:0]  Cs,
  output logic        Frame
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [15:0]      pend;
  logic             pend_v;
  logic [15:0]      disp;
  logic [15:0]      disp_nxt;
  logic             digit_edge;
  logic             frame_edge;
  logic [3:0]       nib_nxt;
  logic             blank_nxt;
  logic [7:0]       dis_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Outputs are computed from next-state idx/disp so they change on the same edge as idx.
  always_comb begin
    digit_edge = (cnt == CNT_LAST);
    frame_edge = digit_edge && (idx == 2'd3);
    idx_nxt    = digit_edge ? idx + 2'd1 : idx;
    disp_nxt   = disp;
    if (frame_edge) begin
      if (Load)        disp_nxt = Value;
      else if (pend_v) disp_nxt = pend;
    end
    nib_nxt   = disp_nxt[{idx_nxt, 2'b00} +: 4];
    blank_nxt = 1'b0;
    case (idx_nxt)
      2'd1:    blank_nxt = Blank_lz && (disp_nxt[15:4] == 12'h000);
      2'd2:    blank_nxt = Blank_lz && (disp_nxt[15:8] == 8'h00);
      2'd3:    blank_nxt = Blank_lz && (disp_nxt[15:12] == 4'h0);
      default: blank_nxt = 1'b0;
    endcase
    dis_nxt = {~Dp[idx_nxt], blank_nxt ? 7'h7F : seg7(nib_nxt)};
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt    <= '0;
      idx    <= 2'd0;
      pend   <= 16'h0000;
      pend_v <= 1'b0;
      disp   <= 16'h0000;
      Cs     <= 4'b1110;
      Dis    <= 8'hC0;
      Frame  <= 1'b0;
    end else begin
      cnt   <= digit_edge ? '0 : cnt + CNT_W'(1);
      idx   <= idx_nxt;
      disp  <= disp_nxt;
      Frame <= frame_edge;
      if (frame_edge) begin
        pend_v <= 1'b0;
      end else if (Load) begin
        pend   <= Value;
        pend_v <= 1'b1;
      end
      if (digit_edge) begin
        Cs  <= ~(4'b0001 << idx_nxt);
        Dis <= dis_nxt;
      end
    end
  end

endmodule
